// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes.
// Misses stall the CPU through an optional write-back then a block fetch.
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state, next_state;

    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tags [8];
    logic [31:0] data [8];

    logic [2:0]  tag_in;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        req;
    logic        hit;
    logic [31:0] line;

    assign tag_in = ADDRESS[7:5];
    assign idx    = ADDRESS[4:2];
    assign off    = ADDRESS[1:0];
    assign req    = READ | WRITE;
    assign line   = data[idx];
    assign hit    = valid[idx] && (tags[idx] == tag_in);

    always_comb begin
        next_state    = state;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        READDATA      = '0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous READ+WRITE is served as a store.
                        if (!WRITE)
                            READDATA = line[{off, 3'b000} +: 8];
                    end else begin
                        BUSYWAIT   = 1'b1;
                        next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tags[idx], idx};
                MEM_WRITEDATA = line;
                if (!MEM_BUSYWAIT)
                    next_state = ALLOCATE;
            end
            ALLOCATE: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
                if (!MEM_BUSYWAIT)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // The stall is released as soon as reset is seen, even with a request held.
        if (RESET)
            BUSYWAIT = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && WRITE && hit) begin
                data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
                dirty[idx]                    <= 1'b1;
            end
            if (state == ALLOCATE && !MEM_BUSYWAIT) begin
                data[idx]  <= MEM_READDATA;
                tags[idx]  <= tag_in;
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameters: none; geometry is fixed at 8 lines x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 READ  input  1  CPU load request; held until BUSYWAIT is low.
REQ-005 WRITE  input  1  CPU store request; held until BUSYWAIT is low.
REQ-006 ADDRESS  input  8  byte address: tag[7:5], index[4:2], offset[1:0].
REQ-007 WRITEDATA  input  8  store data.
REQ-008 READDATA  output  8  load data, feeding the register-file write-data input.
REQ-009 BUSYWAIT  output  1  CPU stall; high while the request is not yet served.
REQ-010 MEM_READ  output  1  block fetch strobe to main memory.
REQ-011 MEM_WRITE  output  1  block write-back strobe to main memory.
REQ-012 MEM_ADDRESS  output  6  block address {tag,index}.
REQ-013 MEM_WRITEDATA  output  32  evicted block; byte k on bits [8k+7:8k].
REQ-014 MEM_READDATA  input  32  fetched block, same byte order.
REQ-015 MEM_BUSYWAIT  input  1  memory busy; low marks the transfer complete.

Function
REQ-016 Per line: valid bit, dirty bit, 3-bit tag, 32-bit data. hit = valid[index] & (tag[index]==ADDRESS[7:5]).
REQ-017 Request = READ|WRITE; if both are high, the request is treated as WRITE.
REQ-018 FSM states: IDLE, WRITEBACK, ALLOCATE. Reset state is IDLE.
REQ-019 IDLE, hit: BUSYWAIT=0 combinationally in the same cycle.
- READ hit: READDATA = byte[offset] of the line, combinationally.
- WRITE hit: byte[offset] <= WRITEDATA at the rising edge, and dirty <= 1.
REQ-020 IDLE, miss with valid & dirty: BUSYWAIT=1; next state WRITEBACK.
REQ-021 IDLE, miss otherwise: BUSYWAIT=1; next state ALLOCATE.
REQ-022 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data, BUSYWAIT=1.
- Stays while MEM_BUSYWAIT=1.
- At the edge where MEM_BUSYWAIT=0: moves to ALLOCATE.
REQ-023 ALLOCATE: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2], BUSYWAIT=1.
- At the edge where MEM_BUSYWAIT=0: data<=MEM_READDATA, tag<=ADDRESS[7:5], valid<=1, dirty<=0; moves to IDLE.
REQ-024 After refill, the held request hits in IDLE on the next cycle and completes as in REQ-019.
REQ-025 MEM_READ and MEM_WRITE are never high together. Both are low in IDLE.
REQ-026 In IDLE, MEM_ADDRESS and MEM_WRITEDATA are 0.
REQ-027 READDATA is 0 whenever no READ hit is being served.
REQ-028 If the request drops during WRITEBACK or ALLOCATE, the transfer completes and the line is filled; no CPU-side write occurs.
REQ-029 Miss latency is 1 + write-back memory cycles + fetch memory cycles + 1 hit cycle.

Reset
REQ-030 RESET high at an edge forces IDLE and clears every valid and dirty bit. It has priority over all other updates.
REQ-031 During reset, BUSYWAIT, MEM_READ and MEM_WRITE are 0 from that edge onward. Tag and data contents need not be cleared.
REQ-032 Reset during WRITEBACK or ALLOCATE abandons the transfer; dirty data is lost by design.

Verification
REQ-033 After reset, READ addr 0x25 with memory block 0x09 = 0xDDCCBBAA and 3-cycle latency:
- BUSYWAIT high, MEM_READ high, MEM_ADDRESS=0x09.
- Line then filled; next cycle READDATA=0xBB, BUSYWAIT=0.
REQ-034 Then WRITE 0x5A to addr 0x27:
- Immediate hit, BUSYWAIT=0, no memory strobe.
- A following READ 0x27 returns 0x5A.
REQ-035 Then READ addr 0x45 (same index 1, tag 2):
- WRITEBACK with MEM_ADDRESS=0x09, MEM_WRITEDATA=0x5ACCBBAA.
- Then ALLOCATE with MEM_ADDRESS=0x11.
REQ-036 READ and WRITE both high on a miss follows the write path. Afterwards the line has dirty=1 and holds WRITEDATA at the offset.
REQ-037 RESET asserted mid-ALLOCATE:
- MEM_READ=0 and BUSYWAIT=0 after that edge.
- A re-read of the same address misses again.
